// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register: 1-cycle latency, order-preserving, optional 2-entry skid buffer.
// Backpressure: SKID_EN=1 gives a registered in_ready_o; SKID_EN=0 gives a combinational ready.
module pipe_stage_skid #(
  parameter int                DATA_W      = 128,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(128'h0000_0013_0000_0000_0000_0000_0000_0000),
  parameter bit                SKID_EN     = 1'b1,
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_out_vld;
  logic [DATA_W-1:0]   r_main_dat;
  logic [DATA_W-1:0]   w_skid_dat;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_main_ld;
  logic w_main_from_skid;
  logic w_skid_ld;

  assign w_in_xfer   = in_valid_i & in_ready_o;
  assign w_out_xfer  = r_out_vld & out_ready_i;
  assign out_valid_o = r_out_vld;
  assign out_data_o  = r_main_dat;
  assign stall_cnt_o = r_stall_cnt;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_FULL;
          w_main_ld   = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_ld = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_in_xfer && SKID_EN) begin
          w_state_nxt = ST_SKID;
          w_skid_ld   = 1'b1;
        end
      end
      ST_SKID: begin
        if (w_out_xfer) begin
          w_state_nxt      = ST_FULL;
          w_main_ld        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush kills every held entry and any same-cycle input.
    if (flush_i) begin
      w_state_nxt      = ST_EMPTY;
      w_main_ld        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_ld        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_out_vld  <= 1'b0;
      r_main_dat <= BUBBLE_DATA;
    end else begin
      r_state   <= w_state_nxt;
      r_out_vld <= (w_state_nxt != ST_EMPTY);
      if (flush_i)
        r_main_dat <= BUBBLE_DATA;
      else if (w_main_ld)
        r_main_dat <= w_main_from_skid ? w_skid_dat : in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (r_out_vld && !out_ready_i && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
  end

  generate
    if (SKID_EN) begin : g_skid
      logic [DATA_W-1:0] r_skid_dat;
      logic              r_in_rdy;

      // Ready comes from the next state, so it never depends combinationally on out_ready_i.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_skid_dat <= BUBBLE_DATA;
          r_in_rdy   <= 1'b1;
        end else begin
          r_in_rdy <= (w_state_nxt != ST_SKID);
          if (flush_i)
            r_skid_dat <= BUBBLE_DATA;
          else if (w_skid_ld)
            r_skid_dat <= in_data_i;
        end
      end

      assign w_skid_dat = r_skid_dat;
      assign in_ready_o = r_in_rdy;
    end else begin : g_noskid
      assign w_skid_dat = BUBBLE_DATA;
      assign in_ready_o = ~r_out_vld | out_ready_i;
    end
  endgenerate

endmodule
